// File: rtl/sqrt_result_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// sqrt_result_bcd_converter_if
//  Handshake/data bundle between the square-root unit (master) and the
//  binary-to-BCD converter (slave).
//  Signals:
//   start     master->slave  conversion request (root unit's ready)
//   data_in   master->slave  unsigned binary root, sampled on accept
//   busy      slave->master  conversion in progress
//   done      slave->master  one-cycle pulse, bcd_out/overflow just updated
//   bcd_out   slave->master  packed BCD, digit 0 in bits [3:0]
//   overflow  slave->master  value did not fit in DIGITS digits
//   seg_out   slave->master  7-seg codes, only when SQRT_BCD_SEG7_EN is defined
//  Optional feature macro: SQRT_BCD_SEG7_EN
// ---------------------------------------------------------------------------
interface sqrt_result_bcd_converter_if #(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 5
);
  logic                     start;
  logic [WORD_LENGTH-1:0]   data_in;
  logic                     busy;
  logic                     done;
  logic [4*DIGITS-1:0]      bcd_out;
  logic                     overflow;
`ifdef SQRT_BCD_SEG7_EN
  logic [7*DIGITS-1:0]      seg_out;

  modport master (
    output start, data_in,
    input  busy, done, bcd_out, overflow, seg_out
  );
  modport slave (
    input  start, data_in,
    output busy, done, bcd_out, overflow, seg_out
  );
`else
  modport master (
    output start, data_in,
    input  busy, done, bcd_out, overflow
  );
  modport slave (
    input  start, data_in,
    output busy, done, bcd_out, overflow
  );
`endif
endinterface

// File: rtl/sqrt_result_bcd_converter.sv
// ---------------------------------------------------------------------------
// sqrt_result_bcd_converter
//  Captures the square-root result word and converts it to packed BCD with
//  shift-add-3 (double dabble), one input bit per clock. The last converted
//  value is held on bcd_out/overflow until the next conversion completes.
//  Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    sqrt_result_bcd_converter_if.slave (start, data_in, busy, done,
//          bcd_out, overflow, and seg_out when enabled)
//  Optional feature macro: SQRT_BCD_SEG7_EN adds registered active-low
//  seven-segment codes {g,f,e,d,c,b,a} per digit on seg_out.
// ---------------------------------------------------------------------------
module sqrt_result_bcd_converter #(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  sqrt_result_bcd_converter_if.slave    bus
);

  localparam int CNT_W = $clog2(WORD_LENGTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [WORD_LENGTH-1:0] r_shift;
  logic [BCD_W-1:0]       r_scratch;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic [BCD_W-1:0]       r_bcd;
  logic                   r_ovf_out;

  logic                   w_accept;
  logic                   w_last;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W-1:0]       w_scratch_shift;
  logic [WORD_LENGTH-1:0] w_shift_next;
  logic                   w_out_bit;
  logic                   w_busy;
  logic                   w_done;

  // A new request is taken whenever no conversion is in flight; a request
  // that arrives during SHIFT is simply dropped.
  assign w_accept = bus.start && (r_state != S_SHIFT);
  assign w_last   = (r_count == CNT_W'(WORD_LENGTH - 1));

  // Add-3 is applied to each pre-shift digit independently; a digit >= 5
  // becomes at most 12, so the 4-bit sum never carries into its neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  // {scratch, shift} << 1; the MSB of the adjusted top digit falls off the
  // end, which is exactly the "does not fit" condition.
  assign w_scratch_shift = {w_adj[BCD_W-2:0], r_shift[WORD_LENGTH-1]};
  assign w_shift_next    = {r_shift[WORD_LENGTH-2:0], 1'b0};
  assign w_out_bit       = w_adj[BCD_W-1];

`ifdef SQRT_BCD_SEG7_EN
  logic [7*DIGITS-1:0] r_seg;
  logic [7*DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_decode = 7'b1000000;
      4'd1:    seg7_decode = 7'b1111001;
      4'd2:    seg7_decode = 7'b0100100;
      4'd3:    seg7_decode = 7'b0110000;
      4'd4:    seg7_decode = 7'b0011001;
      4'd5:    seg7_decode = 7'b0010010;
      4'd6:    seg7_decode = 7'b0000010;
      4'd7:    seg7_decode = 7'b1111000;
      4'd8:    seg7_decode = 7'b0000000;
      4'd9:    seg7_decode = 7'b0010000;
      default: seg7_decode = 7'b1111111;   // non-BCD codes show blank
    endcase
  endfunction

  // Decode the value that is about to be registered into bcd_out so the
  // segment outputs update on the same edge.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign w_seg_next[7*gi +: 7] = seg7_decode(w_scratch_shift[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg <= {DIGITS{7'b1000000}};
    end else if (r_state == S_SHIFT && w_last && !w_accept) begin
      r_seg <= w_seg_next;
    end
  end

  assign bus.seg_out = r_seg;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = bus.start ? S_SHIFT : S_IDLE;
      S_SHIFT: w_state_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_state_next = bus.start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= bus.data_in;
      r_scratch <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_shift   <= w_shift_next;
      r_scratch <= w_scratch_shift;
      r_count   <= CNT_W'(r_count + 1'b1);
      r_ovf     <= r_ovf | w_out_bit;
      // Final shift: publish the result on the edge that enters DONE.
      if (w_last) begin
        r_bcd     <= w_scratch_shift;
        r_ovf_out <= r_ovf | w_out_bit;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_ovf_out;

endmodule

// File: tb/tb_sqrt_result_bcd_converter.sv
module tb_sqrt_result_bcd_converter;

  logic clk;
  logic reset;

  sqrt_result_bcd_converter_if #(.WORD_LENGTH(16), .DIGITS(5)) bus ();
  sqrt_result_bcd_converter_if #(.WORD_LENGTH(16), .DIGITS(4)) bus4 ();

  sqrt_result_bcd_converter #(.WORD_LENGTH(16), .DIGITS(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sqrt_result_bcd_converter #(.WORD_LENGTH(16), .DIGITS(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] d;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  logic [6:0] seg_tab[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by plain division, overflow by magnitude.
  function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int digits);
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  function automatic logic [34:0] ref_seg(input logic [19:0] b);
    logic [34:0] s;
    s = '0;
    for (int i = 0; i < 5; i++) s[7*i +: 7] = seg_tab[int'(b[4*i +: 4])];
    return s;
  endfunction

  // Start one conversion on the 5-digit unit and wait for done. Checks
  // latency, busy during the conversion and that bcd_out stays put.
  task automatic run_conv(input logic [15:0] d, output logic [19:0] bcd,
                          output logic ovf, output logic [34:0] seg);
    int cyc;
    int unstable;
    int busy_low;
    logic [19:0] held;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    held        = bus.bcd_out;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 16'($urandom);
    cyc      = 1;
    unstable = 0;
    busy_low = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.bcd_out !== held) unstable++;
      if (bus.busy !== 1'b1) busy_low++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd17);
    chk("hold_during_busy", 64'(unstable + busy_low), 64'd0);
    bcd = bus.bcd_out;
    ovf = bus.overflow;
`ifdef SQRT_BCD_SEG7_EN
    seg = bus.seg_out;
`else
    seg = '0;
`endif
    $display("[TB] conv d=%0d bcd=%05h ovf=%0b cycles=%0d", d, bcd, ovf, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] got_bcd;
    logic        got_ovf;
    logic [34:0] got_seg;
    int          dones;
    int          first_done;
    int          done_cyc[2];
    logic [19:0] done_bcd[2];
    logic [15:0] rd;
    int          cyc;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0]  = '{16'd255,   20'h00255, 1'b0};
    vecs[1]  = '{16'hFFFF,  20'h65535, 1'b0};
    vecs[2]  = '{16'd0,     20'h00000, 1'b0};
    vecs[3]  = '{16'd1,     20'h00001, 1'b0};
    vecs[4]  = '{16'd9,     20'h00009, 1'b0};
    vecs[5]  = '{16'd10,    20'h00010, 1'b0};
    vecs[6]  = '{16'd8,     20'h00008, 1'b0};
    vecs[7]  = '{16'd9999,  20'h09999, 1'b0};
    vecs[8]  = '{16'd10000, 20'h10000, 1'b0};
    vecs[9]  = '{16'd12345, 20'h12345, 1'b0};
    vecs[10] = '{16'd50000, 20'h50000, 1'b0};
    vecs[11] = '{16'd40960, 20'h40960, 1'b0};

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.data_in  = '0;
    bus4.start   = 1'b0;
    bus4.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
`ifdef SQRT_BCD_SEG7_EN
    chk("rst_seg", 64'(bus.seg_out), 64'({5{7'b1000000}}));
`endif
    reset = 1'b1;

    // Table-driven conversions
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].d, got_bcd, got_ovf, got_seg);
      chk($sformatf("vec%0d_bcd", i), 64'(got_bcd), 64'(vecs[i].bcd));
      chk($sformatf("vec%0d_ovf", i), 64'(got_ovf), 64'(vecs[i].ovf));
`ifdef SQRT_BCD_SEG7_EN
      chk($sformatf("vec%0d_seg", i), 64'(got_seg), 64'(ref_seg(vecs[i].bcd)));
`endif
    end

    // Random conversions against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      rd = 16'($urandom_range(0, 65535));
      run_conv(rd, got_bcd, got_ovf, got_seg);
      chk("rand_bcd", 64'(got_bcd), 64'(ref_bcd(int'(rd), 5)));
      chk("rand_ovf", 64'(got_ovf), 64'(ref_ovf(int'(rd), 5)));
`ifdef SQRT_BCD_SEG7_EN
      chk("rand_seg", 64'(got_seg), 64'(ref_seg(ref_bcd(int'(rd), 5))));
`endif
    end

    // Start while busy is ignored: single done at 17 with the first value
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'd100;
    dones = 0;
    first_done = -1;
    got_bcd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) begin bus.start = 1'b1; bus.data_in = 16'd7; end
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin first_done = c; got_bcd = bus.bcd_out; end
      end
    end
    $display("[TB] busy-ignore dones=%0d first=%0d bcd=%05h", dones, first_done, got_bcd);
    chk("ignore_dones", 64'(dones), 64'd1);
    chk("ignore_cycle", 64'(first_done), 64'd17);
    chk("ignore_bcd", 64'(got_bcd), 64'h00100);

    // Start held high: back-to-back conversions every 17 cycles
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'd42;
    dones = 0;
    done_cyc[0] = -1; done_cyc[1] = -1;
    done_bcd[0] = '0; done_bcd[1] = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.data_in = 16'd9;
      if (bus.done) begin
        if (dones < 2) begin done_cyc[dones] = c; done_bcd[dones] = bus.bcd_out; end
        dones++;
      end
      if (c == 34) bus.start = 1'b0;
    end
    $display("[TB] held-start dones=%0d at %0d,%0d bcd %05h,%05h",
             dones, done_cyc[0], done_cyc[1], done_bcd[0], done_bcd[1]);
    chk("b2b_dones", 64'(dones), 64'd2);
    chk("b2b_cyc0", 64'(done_cyc[0]), 64'd17);
    chk("b2b_cyc1", 64'(done_cyc[1]), 64'd34);
    chk("b2b_bcd0", 64'(done_bcd[0]), 64'h00042);
    chk("b2b_bcd1", 64'(done_bcd[1]), 64'h00009);

    // Reset mid-conversion after a non-zero result
    run_conv(16'd54321, got_bcd, got_ovf, got_seg);
    chk("pre_rst_bcd", 64'(got_bcd), 64'h54321);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'd999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_bcd", 64'(bus.bcd_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_bcd", 64'(bus.bcd_out), 64'd0);
    chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
`ifdef SQRT_BCD_SEG7_EN
    chk("mid_rst_seg", 64'(bus.seg_out), 64'({5{7'b1000000}}));
`endif
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    $display("[TB] reset-abort dones=%0d", dones);
    chk("mid_rst_no_done", 64'(dones), 64'd0);

    // Four-digit unit: overflow case then random values
    for (int i = 0; i < 9; i++) begin
      rd = (i == 0) ? 16'd12345 : 16'($urandom_range(0, 65535));
      @(negedge clk);
      bus4.start   = 1'b1;
      bus4.data_in = rd;
      @(negedge clk);
      bus4.start = 1'b0;
      cyc = 1;
      while (!bus4.done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      $display("[TB] conv4 d=%0d bcd=%04h ovf=%0b cycles=%0d", rd, bus4.bcd_out, bus4.overflow, cyc);
      chk("d4_latency", 64'(cyc), 64'd17);
      chk("d4_bcd", 64'(bus4.bcd_out), 64'(ref_bcd(int'(rd), 4)));
      chk("d4_ovf", 64'(bus4.overflow), 64'(ref_ovf(int'(rd), 4)));
      if (i == 0) begin
        chk("d4_12345_bcd", 64'(bus4.bcd_out), 64'h2345);
        chk("d4_12345_ovf", 64'(bus4.overflow), 64'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
